// File: rtl/board_bcd_converter_pkg.sv
// -----------------------------------------------------------------------------
// board_bcd_converter_pkg
// Shared constants, FSM state encoding and a digit-count helper for the
// board/score binary-to-BCD converter.
// -----------------------------------------------------------------------------
package board_bcd_converter_pkg;

    localparam int TILE_W       = 20;
    localparam int NUM_TILES    = 16;
    localparam int SCORE_W      = 21;
    localparam int BCD_DIGITS   = 7;
    localparam int NUM_ENTRIES  = 17;
    localparam int SHIFT_CYCLES = 21;

    localparam int BOARD_W = TILE_W * NUM_TILES;
    localparam int BCD_W   = 4 * BCD_DIGITS;
    localparam int IDX_W   = 5;
    localparam int CNT_W   = 5;
    localparam int NDIG_W  = 3;

    // Entry 16 is the score; it is the last entry converted.
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        STORE = 2'd3
    } state_t;

    // Number of significant decimal digits; an all-zero value counts as 1.
    function automatic logic [NDIG_W-1:0] count_digits(input logic [BCD_W-1:0] bcd);
        logic [NDIG_W-1:0] n;
        n = NDIG_W'(1);
        for (int i = 1; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                n = NDIG_W'(i + 1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/board_bcd_converter_if.sv
// -----------------------------------------------------------------------------
// board_bcd_converter_if
// Bus between the game controller / display reader and the converter.
//   board   : 16 tiles x 20 bits, tile k at [20k+19:20k]
//   score   : 21-bit game score
//   start   : conversion request
//   busy    : conversion in progress
//   done    : one-cycle pulse when the new result bank becomes visible
//   rd_idx  : read index (0..15 tiles, 16 score)
//   rd_bcd  : 7 packed BCD digits of rd_idx, ones digit at [3:0]
//   rd_ndig : significant digit count of rd_idx (0 when rd_idx > 16)
// master = controller/reader side, slave = converter.
// -----------------------------------------------------------------------------
interface board_bcd_converter_if;
    import board_bcd_converter_pkg::*;

    logic [BOARD_W-1:0] board;
    logic [SCORE_W-1:0] score;
    logic               start;
    logic               busy;
    logic               done;
    logic [IDX_W-1:0]   rd_idx;
    logic [BCD_W-1:0]   rd_bcd;
    logic [NDIG_W-1:0]  rd_ndig;

    modport master (
        output board, score, start, rd_idx,
        input  busy, done, rd_bcd, rd_ndig
    );

    modport slave (
        input  board, score, start, rd_idx,
        output busy, done, rd_bcd, rd_ndig
    );
endinterface

// File: rtl/board_bcd_converter_bin2bcd_step.sv
// -----------------------------------------------------------------------------
// bin2bcd_step
// One double-dabble iteration: every BCD digit >= 5 gets +3, then the
// concatenation {bcd, bin} is shifted left by one bit.
//   bcd_in/bcd_out : 7-digit BCD accumulator
//   bin_in/bin_out : 21-bit binary working value (MSB shifts into bcd)
// Purely combinational.
// -----------------------------------------------------------------------------
module bin2bcd_step
    import board_bcd_converter_pkg::*;
(
    input  logic [BCD_W-1:0]   bcd_in,
    input  logic [SCORE_W-1:0] bin_in,
    output logic [BCD_W-1:0]   bcd_out,
    output logic [SCORE_W-1:0] bin_out
);
    logic [BCD_W-1:0] adj;

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            // 4-bit adder is enough: a digit is at most 9 here, 9+3 = 12.
            assign adj[4*gi +: 4] = (bcd_in[4*gi +: 4] >= 4'd5) ?
                                    bcd_in[4*gi +: 4] + 4'd3 : bcd_in[4*gi +: 4];
        end
    endgenerate

    assign bcd_out = {adj[BCD_W-2:0], bin_in[SCORE_W-1]};
    assign bin_out = {bin_in[SCORE_W-2:0], 1'b0};
endmodule

// File: rtl/board_bcd_converter.sv
// -----------------------------------------------------------------------------
// board_bcd_converter
// Converts the 16 board tiles and the score into packed BCD, one entry at a
// time (LOAD, 21 x SHIFT, STORE = 23 cycles per entry, 391 per board).
// Results go into a back bank; the banks swap after the score entry so the
// front bank seen by readers is always a complete, consistent board.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : board_bcd_converter_if.slave (see interface header)
// -----------------------------------------------------------------------------
module board_bcd_converter
    import board_bcd_converter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    board_bcd_converter_if.slave bus
);
    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [BCD_W-1:0]   acc_reg, acc_next;
    logic [SCORE_W-1:0] val_reg, val_next;
    logic [BOARD_W-1:0] board_shadow_reg;
    logic [SCORE_W-1:0] score_shadow_reg;
    logic               bank_sel_reg;     // selects the front bank
    logic               busy_reg;
    logic               done_reg;
    logic [BCD_W-1:0]   bank_bcd_reg  [2][NUM_ENTRIES];
    logic [NDIG_W-1:0]  bank_ndig_reg [2][NUM_ENTRIES];

    logic [TILE_W-1:0]  tile_w [NUM_TILES];
    logic [SCORE_W-1:0] entry_val;
    logic               accept_start, load_en, shift_en, store_en, last_store;

    generate
        for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_tile
            assign tile_w[gi] = board_shadow_reg[gi*TILE_W +: TILE_W];
        end
    endgenerate

    // Entry being converted: a zero-extended tile, or the score for idx 16.
    always_comb begin
        entry_val = score_shadow_reg;
        if (idx_reg < IDX_W'(NUM_TILES)) begin
            entry_val = SCORE_W'(tile_w[idx_reg[3:0]]);
        end
    end

    bin2bcd_step u_step (
        .bcd_in  (acc_reg),
        .bin_in  (val_reg),
        .bcd_out (acc_next),
        .bin_out (val_next)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (cnt_reg == SHIFT_LAST) state_next = STORE;
            STORE:   state_next = (idx_reg == LAST_IDX) ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    // FSM: datapath strobes
    always_comb begin
        accept_start = 1'b0;
        load_en      = 1'b0;
        shift_en     = 1'b0;
        store_en     = 1'b0;
        last_store   = 1'b0;
        case (state_reg)
            IDLE:    accept_start = bus.start;
            LOAD:    load_en      = 1'b1;
            SHIFT:   shift_en     = 1'b1;
            STORE: begin
                store_en   = 1'b1;
                last_store = (idx_reg == LAST_IDX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg          <= '0;
            cnt_reg          <= '0;
            acc_reg          <= '0;
            val_reg          <= '0;
            board_shadow_reg <= '0;
            score_shadow_reg <= '0;
            bank_sel_reg     <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < NUM_ENTRIES; e++) begin
                    bank_bcd_reg[b][e]  <= '0;
                    bank_ndig_reg[b][e] <= NDIG_W'(1);
                end
            end
        end else begin
            done_reg <= 1'b0;
            if (accept_start) begin
                board_shadow_reg <= bus.board;
                score_shadow_reg <= bus.score;
                idx_reg          <= '0;
                busy_reg         <= 1'b1;
            end
            if (load_en) begin
                val_reg <= entry_val;
                acc_reg <= '0;
                cnt_reg <= '0;
            end
            if (shift_en) begin
                acc_reg <= acc_next;
                val_reg <= val_next;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (store_en) begin
                // The score write and the swap share an edge: the write still
                // targets the old back bank, which becomes the new front.
                bank_bcd_reg[~bank_sel_reg][idx_reg]  <= acc_reg;
                bank_ndig_reg[~bank_sel_reg][idx_reg] <= count_digits(acc_reg);
                if (last_store) begin
                    bank_sel_reg <= ~bank_sel_reg;
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b1;
                end else begin
                    idx_reg <= idx_reg + IDX_W'(1);
                end
            end
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;

    always_comb begin
        bus.rd_bcd  = '0;
        bus.rd_ndig = '0;
        if (bus.rd_idx <= LAST_IDX) begin
            bus.rd_bcd  = bank_bcd_reg[bank_sel_reg][bus.rd_idx];
            bus.rd_ndig = bank_ndig_reg[bank_sel_reg][bus.rd_idx];
        end
    end
endmodule

// File: tb/tb_board_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_board_bcd_converter
// Directed stimulus with a behavioural model (decimal arithmetic, snapshot
// and a cycle countdown) checked every cycle, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_board_bcd_converter;
    import board_bcd_converter_pkg::*;

    localparam int LATENCY = NUM_ENTRIES * (SHIFT_CYCLES + 2);

    logic clk = 1'b0;
    logic rst;
    board_bcd_converter_if bus();

    board_bcd_converter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;
    bit sweep_en = 1'b0;

    // ---------------- behavioural model ----------------
    int unsigned front_val [NUM_ENTRIES];
    int unsigned snap_val  [NUM_ENTRIES];
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_cnt  = 0;

    function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
        logic [BCD_W-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int unsigned ndigits(input int unsigned v);
        int unsigned n;
        int unsigned x;
        n = 1;
        x = v;
        while (x >= 10) begin
            x = x / 10;
            n++;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            for (int e = 0; e < NUM_ENTRIES; e++) front_val[e] <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_cnt == LATENCY - 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    for (int e = 0; e < NUM_ENTRIES; e++) front_val[e] <= snap_val[e];
                end
                m_cnt <= m_cnt + 1;
            end else if (bus.start) begin
                for (int k = 0; k < NUM_TILES; k++)
                    snap_val[k] <= int'(bus.board[k*TILE_W +: TILE_W]);
                snap_val[NUM_ENTRIES-1] <= int'(bus.score);
                m_busy <= 1'b1;
                m_cnt  <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            logic [BCD_W-1:0] e_bcd;
            int unsigned      e_nd;
            if (bus.rd_idx > LAST_IDX) begin
                e_bcd = '0;
                e_nd  = 0;
            end else begin
                e_bcd = to_bcd(front_val[bus.rd_idx]);
                e_nd  = ndigits(front_val[bus.rd_idx]);
            end
            check("model_busy", 32'(bus.busy), 32'(m_busy));
            check("model_done", 32'(bus.done), 32'(m_done));
            check("model_rd_bcd", 32'(bus.rd_bcd), 32'(e_bcd));
            check("model_rd_ndig", 32'(bus.rd_ndig), e_nd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #3;
        if (sweep_en) bus.rd_idx = (bus.rd_idx == 5'd20) ? 5'd0 : bus.rd_idx + 5'd1;
    endtask

    task automatic read_check(input int idx, input logic [BCD_W-1:0] eb, input int en);
        bit saved;
        saved    = sweep_en;
        sweep_en = 1'b0;
        bus.rd_idx = 5'(idx);
        #1;
        $display("read idx=%0d bcd=0x%07h ndig=%0d", idx, bus.rd_bcd, bus.rd_ndig);
        check("lit_rd_bcd", 32'(bus.rd_bcd), 32'(eb));
        check("lit_rd_ndig", 32'(bus.rd_ndig), 32'(en));
        sweep_en = saved;
    endtask

    task automatic pulse_and_wait(input string name);
        int lat;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (lat < 1000) begin
            tick();
            lat++;
            if (bus.done) break;
        end
        $display("conversion %s: done after %0d edges", name, lat);
        check(name, 32'(lat), 32'(LATENCY));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        int gap;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.board  = '0;
        bus.score  = '0;
        bus.rd_idx = '0;
        #1 rst = 1'b0;
        check_en = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Reset state
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < NUM_ENTRIES; i++) read_check(i, 28'h0, 1);

        // Single tile and score
        bus.board = '0;
        bus.board[5*TILE_W +: TILE_W] = 20'd2048;
        bus.score = 21'd1234567;
        sweep_en  = 1'b1;
        pulse_and_wait("latency_basic");
        read_check(5, 28'h0002048, 4);
        read_check(16, 28'h1234567, 7);
        read_check(0, 28'h0, 1);

        // Maximum values
        for (int k = 0; k < NUM_TILES; k++) bus.board[k*TILE_W +: TILE_W] = 20'hFFFFF;
        bus.score = 21'h1FFFFF;
        pulse_and_wait("latency_max");
        for (int k = 0; k < NUM_TILES; k++) read_check(k, 28'h1048575, 7);
        read_check(16, 28'h2097151, 7);

        // Board change and start while busy are ignored
        for (int k = 0; k < NUM_TILES; k++) bus.board[k*TILE_W +: TILE_W] = 20'(1000*k + 7);
        bus.score = 21'd999999;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (100) tick();
        for (int k = 0; k < NUM_TILES; k++) bus.board[k*TILE_W +: TILE_W] = 20'd5;
        bus.score = 21'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 900; i++) begin
            tick();
            if (bus.done) ndone++;
        end
        $display("busy restart: %0d done pulses", ndone);
        check("busy_restart_done_count", 32'(ndone), 32'd1);
        read_check(3, 28'h0003007, 4);
        read_check(0, 28'h0000007, 1);
        read_check(16, 28'h0999999, 6);

        // Reset mid-conversion
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (199) tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (bus.done) ndone++;
        end
        $display("reset abort: %0d done pulses", ndone);
        check("reset_abort_done_count", 32'(ndone), 32'd0);
        read_check(5, 28'h0, 1);
        read_check(16, 28'h0, 1);
        pulse_and_wait("latency_after_reset");
        read_check(5, 28'h0000005, 1);
        read_check(16, 28'h0000003, 1);

        // start held high: back-to-back conversions
        tick();
        bus.start = 1'b1;
        gap = 0;
        while (gap < 1000) begin
            tick();
            gap++;
            if (bus.done) break;
        end
        check("held_first_done", 32'(gap), 32'(LATENCY + 1));
        for (int r = 0; r < 2; r++) begin
            gap = 0;
            while (gap < 1000) begin
                tick();
                gap++;
                if (bus.done) break;
            end
            $display("back-to-back: done gap %0d edges", gap);
            check("held_done_gap", 32'(gap), 32'(LATENCY + 1));
        end
        bus.start = 1'b0;
        repeat (5) tick();
        check("idle_after_held", 32'(bus.busy), 32'd0);
        read_check(20, 28'h0, 0);
        read_check(17, 28'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/board_bcd_converter.md
BOARD_BCD_CONVERTER -- requirements
Module: board_bcd_converter

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 board  input  320  game board from the game controller; tile k (0..15, row-major, 0 = top-left) at bits [20k+19:20k], unsigned.
REQ-005 score  input  21  game score from the game controller, unsigned.
REQ-006 start  input  1  conversion request; sampled only in IDLE.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when a full conversion has finished and the result banks have swapped.
REQ-009 rd_idx  input  5  read index: 0..15 select tiles, 16 selects score.
REQ-010 rd_bcd  output  28  7 packed BCD digits of entry rd_idx; digit 0 (ones) at [3:0]; combinational from the front bank.
REQ-011 rd_ndig  output  3  significant-digit count of entry rd_idx: 1..7, value 0 reports 1.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, SHIFT and STORE.
REQ-013 IDLE with start=1 at an edge -> snapshot board and score into shadow registers, entry index <= 0, go to LOAD, busy <= 1.
REQ-014 LOAD (1 cycle): working value <= shadow entry zero-extended to 21 bits; BCD accumulator <= 0; bit counter <= 0.
REQ-015 SHIFT (21 cycles): each cycle, add 3 to every BCD digit >= 5, then shift {accumulator, value} left by 1.
REQ-016 STORE (1 cycle): write the 28-bit result and digit count into the back bank at the entry index; if index = 16, go to IDLE; otherwise increment the index and go to LOAD.
REQ-017 STORE of entry 16 SHALL swap front and back banks, drive busy <= 0 and done <= 1 on the same edge; done SHALL clear on the next edge.
REQ-018 Latency SHALL be 17 x 23 = 391 edges: done is high in the cycle after the 391st edge following the edge that sampled start.
REQ-019 start while busy SHALL be ignored, with no queuing; board and score changes during busy SHALL NOT affect results.
REQ-020 start high in the done cycle (IDLE) SHALL be accepted.
REQ-021 The front bank SHALL change only at the swap, so readers never see a partially updated board.
REQ-022 rd_idx > 16 SHALL give rd_bcd = 0 and rd_ndig = 0.
REQ-023 Arithmetic: 7 digits cover the maximum 2097151; no overflow is possible; digit adders are 4 bits wide.

Reset
REQ-024 rst low SHALL asynchronously force IDLE, busy = 0, done = 0, bank select = 0, entry index = 0, and clear both banks to 0 with digit count 1; rd_bcd then reads 0 and rd_ndig reads 1 for idx 0..16.
REQ-025 Reset mid-conversion SHALL abort the conversion with no done pulse; the first start after release SHALL run a full 391-edge conversion.

Structure
REQ-026 The shared package SHALL hold TILE_W=20, NUM_TILES=16, SCORE_W=21, BCD_DIGITS=7, NUM_ENTRIES=17, SHIFT_CYCLES=21, and the FSM state encoding.
REQ-027 One combinational sub-module, bin2bcd_step, SHALL implement one add-3-and-shift iteration; the sequencer, shadow registers and the two banks stay in board_bcd_converter.

Verification
REQ-028 Reset, then read idx 0..16 -> rd_bcd = 0, rd_ndig = 1 for all; busy = 0, done = 0.
REQ-029 Tile 5 = 2048, score = 1234567, start pulse -> done exactly 391 edges later; idx 5 = 0x0002048 with ndig 4; idx 16 = 0x1234567 with ndig 7.
REQ-030 All tiles = 1048575 -> every tile reads 0x1048575 with ndig 7; score = 2097151 -> 0x2097151.
REQ-031 Change board and re-pulse start mid-conversion -> results match the first snapshot; rd_bcd keeps its old values until done; one done only.
REQ-032 Drive rst low at edge 200 of a conversion -> no done; banks read 0; a restart completes in 391 edges.
REQ-033 start held high continuously -> back-to-back conversions with done every 392 edges; rd_idx = 20 -> rd_bcd = 0, rd_ndig = 0.
